apb_reg_slave: RTL and testbench

// - APB responder at the far end of the AHB-to-APB bridge FSM: decodes Pselx/Penable/Pwrite/Paddr and serves a bank of 32-bit registers.
// - Inserts programmable wait states via Pready and flags bad accesses via Pslverr.
// - Keeps a read-only transfer counter, so the bench can check the bridge's APB sequencing end to end.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_if.sv | 23 ++
 rtl/apb_regfile.sv | 48 ++++
 rtl/apb_reg_slave.sv | 131 +++++++++++++
 tb/tb_apb_reg_slave.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register responder.
package apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Register index width; never below one bit so NUM_REGS=2 still has a port.
    function automatic int idx_width(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/apb_if.sv
// APB bus bundle between the bridge (master) and a register responder (slave).
interface apb_if;

    logic                        Pselx;
    logic                        Penable;
    logic                        Pwrite;
    logic [apb_pkg::APB_AW-1:0]  Paddr;
    logic [apb_pkg::APB_DW-1:0]  Pwdata;
    logic [apb_pkg::APB_DW-1:0]  Prdata;
    logic                        Pready;
    logic                        Pslverr;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );

endinterface

// File: rtl/apb_regfile.sv
// NUM_REGS-1 read/write registers plus a read-only transfer counter in the top slot.
module apb_regfile
    import apb_pkg::*;
#(
    parameter  int NUM_REGS = 8,
    localparam int IW       = idx_width(NUM_REGS)
) (
    input  logic              Hclk,
    input  logic              Hrstn,
    input  logic              we_i,
    input  logic [IW-1:0]     widx_i,
    input  logic [APB_DW-1:0] wdata_i,
    input  logic              inc_i,
    input  logic [IW-1:0]     ridx_i,
    output logic [APB_DW-1:0] rdata_o
);

    localparam logic [IW-1:0] CNT_IDX = IW'(NUM_REGS - 1);

    logic [APB_DW-1:0] regs_q [0:NUM_REGS-2];
    logic [APB_DW-1:0] cnt_q;

    always_ff @(posedge Hclk or negedge Hrstn) begin
        if (!Hrstn) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            if (we_i && (widx_i != CNT_IDX)) begin
                regs_q[widx_i] <= wdata_i;
            end
            if (inc_i) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        if (ridx_i == CNT_IDX) begin
            rdata_o = cnt_q;
        end else begin
            rdata_o = regs_q[ridx_i];
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB responder: decodes the bus, inserts programmable wait states and serves apb_regfile.
//
// state  | meaning
// IDLE   | no transfer; waiting for Pselx & ~Penable
// SETUP  | decoded cycle (IDLE with Pselx & ~Penable): latch address/control/data, capture read data
// ACCESS | wait counter running; Pready once it reaches terminal count
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_STATES = 0
) (
    input  logic Hclk,
    input  logic Hrstn,
    apb_if.slave apb
);

    localparam int                IW        = idx_width(NUM_REGS);
    localparam int                WW        = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [WW-1:0]     WAIT_LOAD = WW'(WAIT_STATES);
    localparam logic [IW-1:0]     CNT_IDX   = IW'(NUM_REGS - 1);
    localparam logic [APB_AW-1:0] WIN_BYTES = APB_AW'(NUM_REGS * 4);

    apb_state_e        state_q, state_d, state_cur;
    logic [WW-1:0]     wait_q, wait_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [APB_DW-1:0] wdata_q, wdata_d;
    logic [APB_DW-1:0] rdata_q, rdata_d;

    logic [APB_AW-1:0] offset;
    logic [IW-1:0]     dec_idx;
    logic              dec_err;
    logic              ready;
    logic              complete;
    logic              rf_we;
    logic              rf_inc;
    logic [APB_DW-1:0] rf_rdata;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap high and fall out of range.
    assign offset  = apb.Paddr - BASE_ADDR;
    assign dec_idx = offset[IW+1:2];
    assign dec_err = (offset >= WIN_BYTES) || (apb.Pwrite && (dec_idx == CNT_IDX));

    always_ff @(posedge Hclk or negedge Hrstn) begin
        if (!Hrstn) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // SETUP is never held in the state flop: it is the IDLE cycle that sees the setup phase,
    // which keeps a zero-wait transfer at two bus cycles.
    always_comb begin
        state_cur = state_q;
        if ((state_q == ST_IDLE) && apb.Pselx && !apb.Penable) begin
            state_cur = ST_SETUP;
        end

        state_d  = state_q;
        wait_d   = wait_q;
        idx_d    = idx_q;
        write_d  = write_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ready    = 1'b0;
        complete = 1'b0;
        rf_we    = 1'b0;
        rf_inc   = 1'b0;

        case (state_cur)
            ST_SETUP: begin
                state_d = ST_ACCESS;
                wait_d  = WAIT_LOAD;
                idx_d   = dec_idx;
                write_d = apb.Pwrite;
                wdata_d = apb.Pwdata;
                err_d   = dec_err;
                rdata_d = (!apb.Pwrite && !dec_err) ? rf_rdata : '0;
            end
            ST_ACCESS: begin
                ready = (wait_q == '0);
                if (!apb.Pselx) begin
                    state_d = ST_IDLE;
                end else if (ready && apb.Penable) begin
                    complete = 1'b1;
                    rf_we    = write_q && !err_q;
                    rf_inc   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (!ready) begin
                    wait_d = wait_q - WW'(1);
                end
            end
            default: ;
        endcase
    end

    assign apb.Pready  = ready;
    assign apb.Pslverr = complete && err_q;
    assign apb.Prdata  = (complete && !err_q) ? rdata_q : '0;

    apb_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .Hclk    (Hclk),
        .Hrstn   (Hrstn),
        .we_i    (rf_we),
        .widx_i  (idx_q),
        .wdata_i (wdata_q),
        .inc_i   (rf_inc),
        .ridx_i  (dec_idx),
        .rdata_o (rf_rdata)
    );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench: three responders (0, 2 and 3 wait states) on one clock, one driven at a time.
module tb_apb_reg_slave;
    import apb_pkg::*;

    localparam logic [31:0] BASE0 = 32'h4000_0100;
    localparam logic [31:0] BASE2 = 32'h0000_0000;
    localparam logic [31:0] BASE3 = 32'h0000_1000;
    localparam logic [1:0]  SEL0  = 2'd0;
    localparam logic [1:0]  SEL2  = 2'd1;
    localparam logic [1:0]  SEL3  = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        pen = 1'b0;
    logic        pwr = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [1:0]  sel = SEL0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] rd;
    logic        er;
    int          n;

    always #5 clk = ~clk;

    apb_if bus0();
    apb_if bus2();
    apb_if bus3();

    assign bus0.Pselx   = psel && (sel == SEL0);
    assign bus0.Penable = pen;
    assign bus0.Pwrite  = pwr;
    assign bus0.Paddr   = paddr;
    assign bus0.Pwdata  = pwdata;
    assign bus2.Pselx   = psel && (sel == SEL2);
    assign bus2.Penable = pen;
    assign bus2.Pwrite  = pwr;
    assign bus2.Paddr   = paddr;
    assign bus2.Pwdata  = pwdata;
    assign bus3.Pselx   = psel && (sel == SEL3);
    assign bus3.Penable = pen;
    assign bus3.Pwrite  = pwr;
    assign bus3.Paddr   = paddr;
    assign bus3.Pwdata  = pwdata;

    always_comb begin
        prdata  = bus0.Prdata;
        pready  = bus0.Pready;
        pslverr = bus0.Pslverr;
        if (sel == SEL2) begin
            prdata  = bus2.Prdata;
            pready  = bus2.Pready;
            pslverr = bus2.Pslverr;
        end else if (sel == SEL3) begin
            prdata  = bus3.Prdata;
            pready  = bus3.Pready;
            pslverr = bus3.Pslverr;
        end
    end

    apb_reg_slave #(.BASE_ADDR(BASE0), .NUM_REGS(8), .WAIT_STATES(0))
        u_dut0 (.Hclk(clk), .Hrstn(rst_n), .apb(bus0));
    apb_reg_slave #(.BASE_ADDR(BASE2), .NUM_REGS(8), .WAIT_STATES(2))
        u_dut2 (.Hclk(clk), .Hrstn(rst_n), .apb(bus2));
    apb_reg_slave #(.BASE_ADDR(BASE3), .NUM_REGS(8), .WAIT_STATES(3))
        u_dut3 (.Hclk(clk), .Hrstn(rst_n), .apb(bus3));

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Full transfer; n = ACCESS cycles up to and including the Pready cycle.
    // scr flips address/data/direction during wait cycles.
    task automatic xfer(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                        input logic scr, output logic [31:0] rdat, output logic err,
                        output int ncyc);
        @(posedge clk); #1;
        psel = 1'b1; pen = 1'b0; pwr = w; paddr = addr; pwdata = wd;
        @(posedge clk); #1;
        pen  = 1'b1;
        ncyc = 0;
        rdat = '0;
        err  = 1'b0;
        do begin
            @(negedge clk);
            ncyc++;
            rdat = prdata;
            err  = pslverr;
            if (!pready && scr) begin
                paddr = ~paddr; pwdata = ~pwdata; pwr = ~pwr;
            end
        end while (!pready && ncyc < 20);
        if (!pready) check_val("xfer_timeout", {31'd0, pready}, 32'd1);
        @(posedge clk); #1;
        psel = 1'b0; pen = 1'b0;
    endtask

    // Starts a transfer and drops Pselx in ACCESS cycle drop_at, before Pready.
    task automatic abort_xfer(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                              input int drop_at);
        @(posedge clk); #1;
        psel = 1'b1; pen = 1'b0; pwr = w; paddr = addr; pwdata = wd;
        @(posedge clk); #1;
        pen = 1'b1;
        for (int k = 1; k <= drop_at; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k == drop_at) psel = 1'b0;
            @(negedge clk);
            check_val($sformatf("abort_rdy_%0d", k), {31'd0, pready}, 32'd0);
        end
        @(posedge clk); #1;
        pen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_pready", {31'd0, pready}, 32'd0);
        check_val("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check_val("rst_prdata", prdata, 32'd0);
        rst_n = 1'b1;

        // Reset mid-ACCESS on the 3-wait-state slave.
        sel = SEL3;
        @(posedge clk); #1;
        psel = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = BASE3 + 32'd8; pwdata = 32'h1111_2222;
        @(posedge clk); #1;
        pen = 1'b1;
        @(negedge clk);
        check_val("midrst_pre_rdy", {31'd0, pready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_pready", {31'd0, pready}, 32'd0);
        check_val("midrst_pslverr", {31'd0, pslverr}, 32'd0);
        check_val("midrst_prdata", prdata, 32'd0);
        psel = 1'b0; pen = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(1'b0, BASE3 + 32'd8, 32'd0, 1'b0, rd, er, n);
        check_val("midrst_reg2", rd, 32'd0);
        check_val("midrst_reg2_err", {31'd0, er}, 32'd0);
        xfer(1'b0, BASE3 + 32'd28, 32'd0, 1'b0, rd, er, n);
        check_val("midrst_cnt", rd, 32'd1);

        // Zero-wait write then read.
        sel = SEL0;
        xfer(1'b1, BASE0 + 32'd8, 32'hDEAD_BEEF, 1'b0, rd, er, n);
        check_val("ws0_wr_cycles", n + 1, 32'd2);
        check_val("ws0_wr_err", {31'd0, er}, 32'd0);
        check_val("ws0_wr_prdata", rd, 32'd0);
        xfer(1'b0, BASE0 + 32'd8, 32'd0, 1'b0, rd, er, n);
        check_val("ws0_rd_cycles", n + 1, 32'd2);
        check_val("ws0_rd_data", rd, 32'hDEAD_BEEF);
        check_val("ws0_rd_err", {31'd0, er}, 32'd0);

        // Three wait states: read timing, aborted write, write with bus changing in ACCESS.
        sel = SEL3;
        xfer(1'b0, BASE3 + 32'd4, 32'd0, 1'b0, rd, er, n);
        check_val("ws3_rd_access", n, 32'd4);
        check_val("ws3_rd_data", rd, 32'd0);
        abort_xfer(1'b1, BASE3 + 32'd4, 32'hA5A5_0F0F, 3);
        xfer(1'b0, BASE3 + 32'd4, 32'd0, 1'b0, rd, er, n);
        check_val("ws3_abort_nowrite", rd, 32'd0);
        xfer(1'b1, BASE3 + 32'd4, 32'hA5A5_0F0F, 1'b1, rd, er, n);
        check_val("ws3_wr_access", n, 32'd4);
        check_val("ws3_wr_err", {31'd0, er}, 32'd0);
        xfer(1'b0, BASE3 + 32'd4, 32'd0, 1'b0, rd, er, n);
        check_val("ws3_wr_commit", rd, 32'hA5A5_0F0F);
        xfer(1'b0, BASE3 + 32'd28, 32'd0, 1'b0, rd, er, n);
        check_val("ws3_cnt", rd, 32'd6);

        // Error responses on the zero-wait slave.
        sel = SEL0;
        xfer(1'b0, BASE0 + 32'd28, 32'd0, 1'b0, rd, er, n);
        check_val("err_cnt_before", rd, 32'd2);
        xfer(1'b1, BASE0 + 32'd28, 32'h0000_0077, 1'b0, rd, er, n);
        check_val("err_wr_cnt", {31'd0, er}, 32'd1);
        check_val("err_wr_cnt_prdata", rd, 32'd0);
        xfer(1'b0, BASE0 + 32'd32, 32'd0, 1'b0, rd, er, n);
        check_val("err_rd_oor", {31'd0, er}, 32'd1);
        check_val("err_rd_oor_prdata", rd, 32'd0);
        xfer(1'b1, BASE0 + 32'h28, 32'h0000_0BAD, 1'b0, rd, er, n);
        check_val("err_wr_oor", {31'd0, er}, 32'd1);
        xfer(1'b0, BASE0 - 32'd4, 32'd0, 1'b0, rd, er, n);
        check_val("err_rd_below", {31'd0, er}, 32'd1);
        xfer(1'b0, BASE0 + 32'd8, 32'd0, 1'b0, rd, er, n);
        check_val("err_reg2_kept", rd, 32'hDEAD_BEEF);
        check_val("err_reg2_ok", {31'd0, er}, 32'd0);
        xfer(1'b0, BASE0 + 32'd11, 32'd0, 1'b0, rd, er, n);
        check_val("unaligned_rd", rd, 32'hDEAD_BEEF);
        xfer(1'b0, BASE0 + 32'd28, 32'd0, 1'b0, rd, er, n);
        check_val("err_cnt_after", rd, 32'd9);

        // Back-to-back after a fresh reset: 5 writes then a counter read, no idle cycles.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        sel = SEL0;
        @(posedge clk); #1;
        psel = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = BASE0; pwdata = 32'h1000_0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val($sformatf("b2b_setup_rdy_%0d", i), {31'd0, pready}, 32'd0);
            @(posedge clk); #1;
            pen = 1'b1;
            @(negedge clk);
            check_val($sformatf("b2b_access_rdy_%0d", i), {31'd0, pready}, 32'd1);
            if (i == 5) check_val("b2b_cnt", prdata, 32'd5);
            @(posedge clk); #1;
            pen = 1'b0;
            if (i < 4) begin
                paddr  = BASE0 + 32'(4 * (i + 1));
                pwdata = 32'h1000_0000 + 32'(i + 1);
            end else if (i == 4) begin
                pwr   = 1'b0;
                paddr = BASE0 + 32'd28;
            end else begin
                psel = 1'b0;
            end
        end
        xfer(1'b0, BASE0 + 32'd12, 32'd0, 1'b0, rd, er, n);
        check_val("b2b_reg3", rd, 32'h1000_0003);

        // Two wait states: Penable without SETUP, then Pselx dropped in the second ACCESS cycle.
        sel = SEL2;
        @(posedge clk); #1;
        psel = 1'b1; pen = 1'b1; pwr = 1'b1; paddr = BASE2 + 32'd12; pwdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            check_val("idle_penable_rdy", {31'd0, pready}, 32'd0);
        end
        @(posedge clk); #1;
        psel = 1'b0; pen = 1'b0;
        abort_xfer(1'b1, BASE2 + 32'd12, 32'h5A5A_5A5A, 2);
        xfer(1'b0, BASE2 + 32'd12, 32'd0, 1'b0, rd, er, n);
        check_val("drop_reg3", rd, 32'd0);
        check_val("ws2_rd_access", n, 32'd3);
        xfer(1'b0, BASE2 + 32'd28, 32'd0, 1'b0, rd, er, n);
        check_val("drop_cnt", rd, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
